// File: rtl/note_lane_engine_if.sv
// Bundle between the VGA timing/debounce stages, the lane engine and the renderer:
// frame sync, speed and buttons flow in, note positions and scoring flow out.
interface note_lane_engine_if;
  logic        vsync;
  logic [1:0]  speed;
  logic [3:0]  btn;
  logic [3:0]  note_valid;
  logic [43:0] note_y;
  logic [15:0] score;
  logic [7:0]  combo;
  logic [7:0]  misses;
  logic        hit_pulse;
  logic        miss_pulse;

  // Driver side: the stages that produce sync, speed and button levels.
  modport master (
    output vsync, speed, btn,
    input  note_valid, note_y, score, combo, misses, hit_pulse, miss_pulse
  );

  // Engine side.
  modport slave (
    input  vsync, speed, btn,
    output note_valid, note_y, score, combo, misses, hit_pulse, miss_pulse
  );
endinterface

// File: rtl/note_lane_engine.sv
// note_lane_engine: four-lane falling-note gameplay core. A vsync falling edge is
// the frame tick; notes spawn from an 8-bit LFSR, fall by 1<<speed pixels per frame
// and are judged against a hit window on button rising edges.
module note_lane_engine #(
  parameter int SPAWN_PERIOD = 30,
  parameter int HIT_Y_MIN    = 400,
  parameter int HIT_Y_MAX    = 440,
  parameter int SCREEN_H     = 480,
  parameter int HIT_POINTS   = 10
) (
  input  logic             clk,
  input  logic             reset,
  note_lane_engine_if.slave io_lane
);

  localparam logic [7:0]  LP_LAST_FRAME = 8'(SPAWN_PERIOD - 1);
  localparam logic [10:0] LP_Y_MIN      = 11'(HIT_Y_MIN);
  localparam logic [10:0] LP_Y_MAX      = 11'(HIT_Y_MAX);
  localparam logic [10:0] LP_SCREEN_H   = 11'(SCREEN_H);
  localparam logic [16:0] LP_POINTS     = 17'(HIT_POINTS);

  logic        r_vsync_q;
  logic [3:0]  r_btn_q;
  logic [7:0]  r_lfsr;
  logic [7:0]  r_frame_cnt;
  logic [3:0]  r_valid;
  logic [10:0] r_y [4];
  logic [15:0] r_score;
  logic [7:0]  r_combo;
  logic [7:0]  r_misses;
  logic        r_hit_pulse;
  logic        r_miss_pulse;

  logic        w_fs;
  logic [3:0]  w_press;
  logic [10:0] w_step;
  logic [10:0] w_moved_y [4];
  logic [3:0]  w_hit;
  logic [3:0]  w_miss;
  logic [3:0]  w_spawn;
  logic        w_spawn_frame;
  logic [1:0]  w_spawn_lane;
  logic [2:0]  w_hit_cnt;
  logic [2:0]  w_miss_cnt;
  logic [16:0] w_score_sum;
  logic [8:0]  w_combo_sum;
  logic [8:0]  w_misses_sum;

  assign w_fs          = r_vsync_q & ~io_lane.vsync;
  assign w_press       = io_lane.btn & ~r_btn_q;
  assign w_step        = 11'd1 << io_lane.speed;
  assign w_spawn_frame = w_fs && (r_frame_cnt == LP_LAST_FRAME);
  assign w_spawn_lane  = r_lfsr[1:0];
  assign w_hit_cnt     = 3'($countones(w_hit));
  assign w_miss_cnt    = 3'($countones(w_miss));
  assign w_score_sum   = {1'b0, r_score} + (17'(w_hit_cnt) * LP_POINTS);
  assign w_combo_sum   = {1'b0, r_combo} + {6'd0, w_hit_cnt};
  assign w_misses_sum  = {1'b0, r_misses} + {6'd0, w_miss_cnt};

  // Per-lane judgement: a hit uses the pre-move y and pre-empts motion and miss.
  always_comb begin
    w_spawn = '0;
    for (int n = 0; n < 4; n++) begin
      w_moved_y[n] = r_y[n] + w_step;
      w_hit[n]     = w_press[n] & r_valid[n] & (r_y[n] >= LP_Y_MIN) & (r_y[n] <= LP_Y_MAX);
      w_miss[n]    = w_fs & r_valid[n] & ~w_hit[n] & (w_moved_y[n] >= LP_SCREEN_H);
    end
    if (w_spawn_frame && !r_valid[w_spawn_lane]) begin
      w_spawn[w_spawn_lane] = 1'b1;
    end
  end

  // Edge-detect history, frame counter and LFSR advance once per frame tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vsync_q   <= 1'b1;
      r_btn_q     <= '0;
      r_lfsr      <= 8'h01;
      r_frame_cnt <= '0;
    end else begin
      r_vsync_q <= io_lane.vsync;
      r_btn_q   <= io_lane.btn;
      if (w_fs) begin
        r_lfsr      <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        r_frame_cnt <= (r_frame_cnt == LP_LAST_FRAME) ? 8'd0 : r_frame_cnt + 8'd1;
      end
    end
  end

  // Note state per lane: hit clears, otherwise fall or fall off, otherwise spawn.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      for (int n = 0; n < 4; n++) begin
        r_y[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (w_hit[n] || w_miss[n]) begin
          r_valid[n] <= 1'b0;
          r_y[n]     <= '0;
        end else if (w_fs && r_valid[n]) begin
          r_y[n] <= w_moved_y[n];
        end else if (w_spawn[n]) begin
          r_valid[n] <= 1'b1;
          r_y[n]     <= '0;
        end
      end
    end
  end

  // Scoring: hits add per lane; any miss in the same cycle zeroes combo afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_score      <= '0;
      r_combo      <= '0;
      r_misses     <= '0;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
    end else begin
      r_score      <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
      r_misses     <= w_misses_sum[8] ? 8'hFF : w_misses_sum[7:0];
      r_hit_pulse  <= |w_hit;
      r_miss_pulse <= |w_miss;
      if (|w_miss) begin
        r_combo <= '0;
      end else begin
        r_combo <= w_combo_sum[8] ? 8'hFF : w_combo_sum[7:0];
      end
    end
  end

  // Pack lane positions for the renderer, lane n at bits [11n+10:11n].
  always_comb begin
    io_lane.note_y = '0;
    for (int n = 0; n < 4; n++) begin
      io_lane.note_y[11*n +: 11] = r_y[n];
    end
  end

  assign io_lane.note_valid = r_valid;
  assign io_lane.score      = r_score;
  assign io_lane.combo      = r_combo;
  assign io_lane.misses     = r_misses;
  assign io_lane.hit_pulse  = r_hit_pulse;
  assign io_lane.miss_pulse = r_miss_pulse;

endmodule

// File: tb/tb_note_lane_engine.sv
// tb_note_lane_engine: directed gameplay scenarios. The stimulus side keeps a small
// behavioural model of the lanes and queues the expected score state for every
// hit/miss strobe; a separate monitor pops that queue whenever a strobe appears.
module tb_note_lane_engine;

  logic clk = 1'b0;
  logic reset;

  note_lane_engine_if lane ();

  note_lane_engine dut (
    .clk    (clk),
    .reset  (reset),
    .io_lane(lane)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         isHit;
    bit         isMiss;
    int         score;
    int         combo;
    int         misses;
    logic [3:0] valid;
  } event_t;

  event_t expQ[$];
  event_t monEv;

  int vectorCount = 0;
  int missCount   = 0;

  // Behavioural model of the game state
  logic [3:0] mValid;
  int         mY [4];
  logic [7:0] mLfsr;
  int         mCnt;
  int         mScore;
  int         mCombo;
  int         mMisses;
  logic       prevVsync;
  logic [3:0] prevBtn;
  int         speedVal;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [10:0] laneY(input int n);
    return lane.note_y[11*n +: 11];
  endfunction

  task automatic modelReset();
    mValid = '0;
    for (int n = 0; n < 4; n++) mY[n] = 0;
    mLfsr     = 8'h01;
    mCnt      = 0;
    mScore    = 0;
    mCombo    = 0;
    mMisses   = 0;
    prevVsync = 1'b1;
    prevBtn   = '0;
  endtask

  task automatic setSpeed(input int s);
    speedVal   = s;
    lane.speed = 2'(s);
  endtask

  // Drives one clock cycle of inputs, advances the model and queues any strobe.
  task automatic applyStimulus(input logic newVsync, input logic [3:0] newBtn);
    logic       fs;
    logic [3:0] press, hit, miss, preValid;
    int         nh, nm, ny, sl;
    event_t     ev;
    fs       = prevVsync & ~newVsync;
    press    = newBtn & ~prevBtn;
    preValid = mValid;
    hit      = '0;
    miss     = '0;
    for (int n = 0; n < 4; n++) begin
      if (press[n] && mValid[n] && mY[n] >= 400 && mY[n] <= 440) hit[n] = 1'b1;
    end
    for (int n = 0; n < 4; n++) begin
      if (hit[n]) begin
        mValid[n] = 1'b0;
        mY[n]     = 0;
      end else if (fs && mValid[n]) begin
        ny = mY[n] + (1 << speedVal);
        if (ny >= 480) begin
          miss[n]   = 1'b1;
          mValid[n] = 1'b0;
          mY[n]     = 0;
        end else begin
          mY[n] = ny;
        end
      end
    end
    if (fs) begin
      if (mCnt == 29) begin
        sl = int'(mLfsr[1:0]);
        if (!preValid[sl]) begin
          mValid[sl] = 1'b1;
          mY[sl]     = 0;
        end
        mCnt = 0;
      end else begin
        mCnt++;
      end
      mLfsr = {mLfsr[6:0], mLfsr[7] ^ mLfsr[5] ^ mLfsr[4] ^ mLfsr[3]};
    end
    nh      = $countones(hit);
    nm      = $countones(miss);
    mScore  = (mScore + 10 * nh > 65535) ? 65535 : mScore + 10 * nh;
    mCombo  = (nm > 0) ? 0 : ((mCombo + nh > 255) ? 255 : mCombo + nh);
    mMisses = (mMisses + nm > 255) ? 255 : mMisses + nm;
    if (nh > 0 || nm > 0) begin
      ev.isHit  = (nh > 0);
      ev.isMiss = (nm > 0);
      ev.score  = mScore;
      ev.combo  = mCombo;
      ev.misses = mMisses;
      ev.valid  = mValid;
      expQ.push_back(ev);
    end
    lane.vsync = newVsync;
    lane.btn   = newBtn;
    prevVsync  = newVsync;
    prevBtn    = newBtn;
    @(posedge clk);
    #2;
  endtask

  task automatic frame();
    applyStimulus(1'b0, prevBtn);
    applyStimulus(1'b1, prevBtn);
  endtask

  task automatic frames(input int count);
    for (int i = 0; i < count; i++) frame();
  endtask

  task automatic compareModel(input string tag);
    checkOutput({tag, ".valid"}, lane.note_valid, mValid);
    for (int n = 0; n < 4; n++) checkOutput({tag, ".y"}, laneY(n), mY[n]);
    checkOutput({tag, ".score"}, lane.score, mScore);
    checkOutput({tag, ".combo"}, lane.combo, mCombo);
    checkOutput({tag, ".misses"}, lane.misses, mMisses);
  endtask

  task automatic doReset();
    checkOutput("queueDrained", expQ.size(), 0);
    expQ.delete();
    reset      = 1'b1;
    lane.vsync = 1'b1;
    lane.btn   = '0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    modelReset();
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always begin
    @(posedge clk);
    #1;
    if (reset !== 1'b1 && (lane.hit_pulse === 1'b1 || lane.miss_pulse === 1'b1)) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedStrobe", {lane.hit_pulse, lane.miss_pulse}, 0);
      end else begin
        monEv = expQ.pop_front();
        checkOutput("evHitPulse", lane.hit_pulse, monEv.isHit);
        checkOutput("evMissPulse", lane.miss_pulse, monEv.isMiss);
        checkOutput("evScore", lane.score, monEv.score);
        checkOutput("evCombo", lane.combo, monEv.combo);
        checkOutput("evMisses", lane.misses, monEv.misses);
        checkOutput("evValid", lane.note_valid, monEv.valid);
      end
    end
  end

  initial begin
    int  foundMask;
    bit  found;
    reset      = 1'b1;
    lane.vsync = 1'b1;
    lane.btn   = '0;
    setSpeed(0);
    modelReset();
    doReset();

    // Reset state and first spawn: LFSR 0x01 shifted 29 times is 0x32 -> lane 2
    checkOutput("rstValid", lane.note_valid, 0);
    checkOutput("rstNoteY", lane.note_y, 0);
    checkOutput("rstScore", lane.score, 0);
    checkOutput("rstCombo", lane.combo, 0);
    checkOutput("rstMisses", lane.misses, 0);
    checkOutput("rstPulses", {lane.hit_pulse, lane.miss_pulse}, 0);
    frames(29);
    checkOutput("valid29", lane.note_valid, 0);
    frame();
    checkOutput("spawn30Valid", lane.note_valid, 4'b0100);
    checkOutput("spawn30Y", laneY(2), 0);

    // Slow fall to the window edge, then a clean hit
    frames(400);
    checkOutput("y400", laneY(2), 400);
    compareModel("pre-hit");
    applyStimulus(1'b1, 4'b0100);
    checkOutput("hitValid", lane.note_valid[2], 0);
    checkOutput("hitScore", lane.score, 10);
    checkOutput("hitCombo", lane.combo, 1);
    checkOutput("hitPulse", lane.hit_pulse, 1);
    applyStimulus(1'b1, 4'b0000);
    checkOutput("hitPulseDrop", lane.hit_pulse, 0);

    // Fast fall with no press: miss on the 60th frame
    doReset();
    setSpeed(3);
    frames(30);
    checkOutput("fastSpawn", lane.note_valid, 4'b0100);
    frames(59);
    checkOutput("y472", laneY(2), 472);
    applyStimulus(1'b0, 4'b0000);
    checkOutput("missValid", lane.note_valid[2], 0);
    checkOutput("missCount", lane.misses, 1);
    checkOutput("missCombo", lane.combo, 0);
    checkOutput("missPulse", lane.miss_pulse, 1);
    applyStimulus(1'b1, 4'b0000);
    checkOutput("missPulseDrop", lane.miss_pulse, 0);

    // Early press, held button, then re-press inside the window
    doReset();
    setSpeed(0);
    frames(30);
    frames(399);
    checkOutput("y399", laneY(2), 399);
    applyStimulus(1'b1, 4'b0100);
    checkOutput("earlyScore", lane.score, 0);
    checkOutput("earlyValid", lane.note_valid[2], 1);
    frame();
    checkOutput("heldY", laneY(2), 400);
    applyStimulus(1'b1, 4'b0100);
    checkOutput("heldScore", lane.score, 0);
    checkOutput("heldValid", lane.note_valid[2], 1);
    applyStimulus(1'b1, 4'b0000);
    frames(5);
    checkOutput("y405", laneY(2), 405);
    applyStimulus(1'b1, 4'b0100);
    checkOutput("repressScore", lane.score, 10);
    checkOutput("repressCombo", lane.combo, 1);
    checkOutput("repressValid", lane.note_valid[2], 0);
    applyStimulus(1'b1, 4'b0000);

    // Press and frame tick in the same cycle at y = 440: hit wins
    doReset();
    frames(30);
    frames(440);
    checkOutput("y440", laneY(2), 440);
    applyStimulus(1'b0, 4'b0100);
    checkOutput("sameCycValid", lane.note_valid[2], 0);
    checkOutput("sameCycY", laneY(2), 0);
    checkOutput("sameCycScore", lane.score, 10);
    checkOutput("sameCycMisses", lane.misses, 0);
    checkOutput("sameCycMissPulse", lane.miss_pulse, 0);
    applyStimulus(1'b1, 4'b0100);
    applyStimulus(1'b1, 4'b0000);
    compareModel("after-same-cycle");

    // Build score to 30 at speed 3, then find a note at y = 250 at speed 1
    doReset();
    setSpeed(3);
    for (int f = 0; f < 400 && mScore < 30; f++) begin
      frame();
      compareModel("play");
      foundMask = 0;
      for (int n = 3; n >= 0; n--) begin
        if (mValid[n] && mY[n] >= 400 && mY[n] <= 440) foundMask = 1 << n;
      end
      if (foundMask != 0) begin
        applyStimulus(1'b1, 4'(foundMask));
        applyStimulus(1'b1, 4'b0000);
      end
    end
    checkOutput("score30", lane.score, 30);
    setSpeed(1);
    found = 1'b0;
    for (int f = 0; f < 400 && !found; f++) begin
      frame();
      for (int n = 0; n < 4; n++) begin
        if (mValid[n] && mY[n] == 250) found = 1'b1;
      end
    end
    checkOutput("reached250", found, 1);
    compareModel("pre-reset");

    // Asynchronous reset mid-cycle clears everything without a clock edge
    #3;
    reset = 1'b1;
    #1;
    checkOutput("asyncValid", lane.note_valid, 0);
    checkOutput("asyncNoteY", lane.note_y, 0);
    checkOutput("asyncScore", lane.score, 0);
    checkOutput("asyncCombo", lane.combo, 0);
    checkOutput("asyncMisses", lane.misses, 0);
    checkOutput("asyncPulses", {lane.hit_pulse, lane.miss_pulse}, 0);
    doReset();
    frames(29);
    checkOutput("reValid29", lane.note_valid, 0);
    frame();
    checkOutput("reSpawnValid", lane.note_valid, 4'b0100);
    checkOutput("reSpawnY", laneY(2), 0);

    repeat (3) @(posedge clk);
    #2;
    checkOutput("finalQueue", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
